// File: rtl/munoc_prog_routing_table.sv
// -----------------------------------------------------------------------------
// munoc_prog_routing_table
//
// Run-time programmable routing table for a muNoC router. One routing vector
// (one-hot output port) is kept per target node in flops and can be rewritten
// at any time through a single-cycle config write port. Lookups go through a
// one-stage registered valid/ready pipeline: an accepted lookup shows up on
// the response outputs on the next cycle. Misses (invalid entry or node out
// of range) fall back to the DEFAULT_OUTPUT port, or to an all-zero (drop)
// vector when DEFAULT_OUTPUT is not a real port.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   lkp_valid/ready   lookup request handshake, lkp_node = target node
//   rsp_valid/ready   response handshake
//   rsp_routing_info  one-hot output port (zero on drop)
//   rsp_miss          lookup missed (invalid entry / node out of range)
//   rsp_router_id     constant ROUTER_ID
//   cfg_wr_en         config write strobe; cfg_wr_clr invalidates the entry
//   cfg_wr_node/info  entry index and routing vector to write
//   cfg_wr_err        one-cycle pulse after a rejected write
//   cfg_cnt_clr       synchronous clear of miss_count
//   miss_count        saturating count of missed lookups
//   parity_err        (parity build only) sticky entry parity error
//
// Optional feature macro: MUNOC_ROUTING_TABLE_PARITY_EN
//   When defined, every entry carries an even-parity bit over {valid, vector}.
//   A lookup whose stored entry fails the parity check is forced to a miss
//   and sets the sticky parity_err output, cleared only by reset.
// -----------------------------------------------------------------------------

`ifndef NOT_SELECTED
`define NOT_SELECTED 0
`endif

module munoc_prog_routing_table #(
  parameter int NETWORK_TYPE   = `NOT_SELECTED,
  parameter int ROUTER_ID      = -1,
  parameter int BW_NODE_ID     = 4,
  parameter int NUM_NODE       = 16,
  parameter int NUM_OUTPUT     = 5,
  parameter int DEFAULT_OUTPUT = 0,
  parameter int BW_MISS_CNT    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lkp_valid,
  output logic                   lkp_ready,
  input  logic [BW_NODE_ID-1:0]  lkp_node,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [NUM_OUTPUT-1:0]  rsp_routing_info,
  output logic                   rsp_miss,
  output logic [31:0]            rsp_router_id,
  input  logic                   cfg_wr_en,
  input  logic                   cfg_wr_clr,
  input  logic [BW_NODE_ID-1:0]  cfg_wr_node,
  input  logic [NUM_OUTPUT-1:0]  cfg_wr_info,
  output logic                   cfg_wr_err,
  input  logic                   cfg_cnt_clr,
  output logic [BW_MISS_CNT-1:0] miss_count
`ifdef MUNOC_ROUTING_TABLE_PARITY_EN
  ,
  output logic                   parity_err
`endif
);

  // Storage is sized to the full node-id space so every index is in bounds;
  // entries at or above NUM_NODE are never written and stay at reset value.
  localparam int DEPTH = 1 << BW_NODE_ID;
  localparam logic [BW_NODE_ID:0] NODE_LIMIT = (BW_NODE_ID + 1)'(NUM_NODE);
  localparam logic [NUM_OUTPUT-1:0] DEFAULT_VEC =
    ((DEFAULT_OUTPUT >= 0) && (DEFAULT_OUTPUT < NUM_OUTPUT)) ?
    (NUM_OUTPUT'(1) << DEFAULT_OUTPUT) : '0;
  localparam logic [BW_MISS_CNT-1:0] CNT_MAX = '1;

  // Elaboration-time sanity check of the configuration.
  generate
    if ((NUM_NODE < 1) || (NUM_NODE > (1 << BW_NODE_ID)) || (NETWORK_TYPE < 0)) begin : g_bad_cfg
      $error("munoc_prog_routing_table: illegal NUM_NODE/BW_NODE_ID/NETWORK_TYPE");
    end
  endgenerate

  function automatic logic node_in_range(input logic [BW_NODE_ID-1:0] node);
    return ({1'b0, node} < NODE_LIMIT);
  endfunction

  function automatic logic is_onehot(input logic [NUM_OUTPUT-1:0] vec);
    return (vec != '0) && ((vec & (vec - NUM_OUTPUT'(1))) == '0);
  endfunction

`ifdef MUNOC_ROUTING_TABLE_PARITY_EN
  // Even parity: the stored bit makes the XOR of {valid, vector, parity} zero.
  function automatic logic even_parity(input logic valid, input logic [NUM_OUTPUT-1:0] vec);
    return ^{valid, vec};
  endfunction
`endif

  logic                  valid_r [DEPTH];
  logic [NUM_OUTPUT-1:0] info_r  [DEPTH];
`ifdef MUNOC_ROUTING_TABLE_PARITY_EN
  logic                  par_r   [DEPTH];
`endif

  logic                  wr_ok_s;
  logic                  lkp_accept_s;
  logic                  lkp_in_range_s;
  logic                  bypass_s;
  logic                  lkp_hit_s;
  logic [NUM_OUTPUT-1:0] lkp_vec_s;
  logic                  par_bad_s;
  logic                  res_miss_s;
  logic [NUM_OUTPUT-1:0] res_info_s;

  assign rsp_router_id  = 32'(ROUTER_ID);
  assign lkp_ready      = !rsp_valid || rsp_ready;
  assign lkp_accept_s   = lkp_valid && lkp_ready;
  assign lkp_in_range_s = node_in_range(lkp_node);
  assign wr_ok_s        = cfg_wr_en && node_in_range(cfg_wr_node) &&
                          (cfg_wr_clr || is_onehot(cfg_wr_info));
  // A same-cycle write to the looked-up node is forwarded (write-first).
  assign bypass_s       = wr_ok_s && (cfg_wr_node == lkp_node);

  // Table storage: accepted writes update or invalidate one entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_r[i] <= 1'b0;
        info_r[i]  <= '0;
`ifdef MUNOC_ROUTING_TABLE_PARITY_EN
        par_r[i]   <= 1'b0;
`endif
      end
    end else if (wr_ok_s) begin
      valid_r[cfg_wr_node] <= !cfg_wr_clr;
      info_r[cfg_wr_node]  <= cfg_wr_clr ? '0 : cfg_wr_info;
`ifdef MUNOC_ROUTING_TABLE_PARITY_EN
      par_r[cfg_wr_node]   <= cfg_wr_clr ? 1'b0 : even_parity(1'b1, cfg_wr_info);
`endif
    end
  end

  // Lookup result: forwarded write, stored entry, or default route on miss.
  always_comb begin
    lkp_hit_s = 1'b0;
    lkp_vec_s = '0;
    par_bad_s = 1'b0;
    if (!lkp_in_range_s) begin
      lkp_hit_s = 1'b0;
      lkp_vec_s = '0;
    end else if (bypass_s) begin
      lkp_hit_s = !cfg_wr_clr;
      lkp_vec_s = cfg_wr_clr ? '0 : cfg_wr_info;
    end else begin
      lkp_hit_s = valid_r[lkp_node];
      lkp_vec_s = info_r[lkp_node];
`ifdef MUNOC_ROUTING_TABLE_PARITY_EN
      par_bad_s = ((^{valid_r[lkp_node], info_r[lkp_node]}) ^ par_r[lkp_node]) != 1'b0;
`endif
    end
    res_miss_s = !lkp_hit_s || par_bad_s;
    res_info_s = res_miss_s ? DEFAULT_VEC : lkp_vec_s;
  end

  // Response stage: load on accept, drop after handshake, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid        <= 1'b0;
      rsp_routing_info <= '0;
      rsp_miss         <= 1'b0;
    end else if (lkp_accept_s) begin
      rsp_valid        <= 1'b1;
      rsp_routing_info <= res_info_s;
      rsp_miss         <= res_miss_s;
    end else if (rsp_ready) begin
      rsp_valid        <= 1'b0;
    end else begin
      rsp_valid        <= rsp_valid;
    end
  end

  // Rejected-write pulse, one cycle after the offending strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_wr_err <= 1'b0;
    end else begin
      cfg_wr_err <= cfg_wr_en && !wr_ok_s;
    end
  end

  // Saturating miss counter; the clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_count <= '0;
    end else if (cfg_cnt_clr) begin
      miss_count <= '0;
    end else if (lkp_accept_s && res_miss_s && (miss_count != CNT_MAX)) begin
      miss_count <= miss_count + BW_MISS_CNT'(1);
    end else begin
      miss_count <= miss_count;
    end
  end

`ifdef MUNOC_ROUTING_TABLE_PARITY_EN
  // Sticky parity error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err <= 1'b0;
    end else if (lkp_accept_s && par_bad_s) begin
      parity_err <= 1'b1;
    end else begin
      parity_err <= parity_err;
    end
  end
`endif

endmodule
